bit_serializer_tx: RTL and testbench
====================================

// Module: bit_serializer_tx
// PURPOSE
//  Parallel-to-serial front end that feeds the Mealy sequence detectors (x input).
//  Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first,
//  one bit per clk, with a qualifying valid.
//  Back-to-back words stream with no gap cycles.
// PARAMETERS
//  WIDTH  16  data word width in bits; legal range WIDTH >= 2
// PORTS
//  clk         in   1      single clock, all state on posedge
//  rst         in   1      asynchronous, active-high reset
//  din         in   WIDTH  parallel word; sampled only on handshake
//  din_valid   in   1      producer has a word on din
//  din_ready   out  1      block can accept a word this cycle
//  sout        out  1      serial bit; drives detector x
//  sout_valid  out  1      sout carries a live bit this cycle
//  word_done   out  1      high during the final serial cycle of each word
//  busy        out  1      high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, shift reg=0, bit counter=0.
//    sout=0, sout_valid=0, word_done=0, busy=0; din_ready forced 0 while rst=1.
//  - Handshake: a word is accepted on a posedge where din_valid && din_ready.
//    din is ignored at all other times; din_valid may drop any cycle without effect.
//  - FSM states: IDLE, SHIFT, PAR (PAR exists only with SER_PARITY_EN).
//  - IDLE: din_ready=1, sout_valid=0, sout=0.
//    On accept: load shreg<=din, cnt<=WIDTH-1, go to SHIFT.
//  - SHIFT:
//    - sout=shreg[WIDTH-1], sout_valid=1; each clk shifts shreg left by 1 and decrements cnt.
//    - Last bit is the cycle with cnt==0; word_done=1 in that cycle (no parity).
//    - din_ready=1 only in the last-bit cycle.
//    - Accept in that cycle: reload and stay in SHIFT, so the new MSB appears next cycle (zero gap).
//    - No accept in that cycle: go to IDLE.
//  - Latency: accept edge -> MSB on sout in the following cycle (1 clk); a word occupies exactly WIDTH cycles.
//  - All outputs come from registers or a state decode; sout has no combinational path from din.
//  - Reset mid-word aborts the word immediately. No partial bits are emitted after rst deasserts.
//  - cnt is $clog2(WIDTH) bits wide and never wraps below 0; state is always reloaded or exited at cnt==0.
// CONFIGURATION
//  SER_PARITY_EN defined:
//   - After the last data bit, SHIFT goes to PAR for one cycle.
//   - In PAR: sout = ^word (even parity over the accepted word), sout_valid=1, word_done=1.
//   - word_done moves from the last data bit to the PAR cycle.
//   - din_ready=1 in PAR and not in the last data-bit cycle; accept in PAR -> SHIFT with the new word.
//   - A word then occupies WIDTH+1 cycles.
//  SER_PARITY_EN undefined: no PAR state and no parity logic; behaviour exactly as in BEHAVIOUR.
// TESTING
//  1. Reset: rst=1 with din_valid=1.
//     -> sout=0, sout_valid=0, din_ready=0, busy=0. After release, din_ready=1 in the first IDLE cycle.
//  2. Single word: din=16'h5B56, one-cycle valid.
//     -> sout over 16 cycles = 0101101101010110; word_done only on cycle 16; then IDLE, din_ready=1.
//  3. Streaming: words 16'hFFFF then 16'h0001 held valid.
//     -> 32 consecutive sout_valid cycles, no gap, bits 1x16 then 0x15,1.
//     -> din_ready pulses exactly on cycles 16 and 32.
//  4. Detector chain: 16'h5B56 into mealy_nov_1011 (x=sout).
//     -> exactly two z pulses, coincident with serial bit indices 4 and 14 (0-based).
//  5. Reset mid-word: assert rst during bit 7 of 16'hAAAA.
//     -> outputs 0 asynchronously; after release, next word starts cleanly with its MSB.
//  6. SER_PARITY_EN, din=16'h0007.
//     -> 16 data bits, then PAR cycle with sout=1 and word_done=1; 17 valid cycles per word.

Source files
------------

// File: rtl/bit_serializer_tx_if.sv
// Handshake and serial-output bundle for bit_serializer_tx.
// The producer drives din/din_valid through the master modport; the serializer
// owns every other signal through the slave modport.
interface bit_serializer_tx_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sout,
        input  sout_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sout,
        output sout_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/bit_serializer_tx.sv
// Parallel-to-serial transmitter: accepts WIDTH-bit words on a valid/ready
// handshake and emits them MSB-first, one bit per clock, with no gap between
// back-to-back words.
// Optional feature macro: SER_PARITY_EN appends one even-parity bit per word
// (word_done then marks the parity cycle instead of the last data bit).
module bit_serializer_tx #(
    parameter int unsigned WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    bit_serializer_tx_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready;
    logic               accept;
    logic               last_bit;
`ifdef SER_PARITY_EN
    logic               par_q;
`endif

    assign accept   = bus.din_valid && ready;
    assign last_bit = (state_q == StShift) && (cnt_q == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register and bit counter: load on accept, otherwise shift while in SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (accept) begin
            shreg_q <= bus.din;
            cnt_q   <= CNT_W'(WIDTH - 1);
`ifdef SER_PARITY_EN
            par_q   <= ^bus.din;
`endif
        end else if (state_q == StShift) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            // Saturate at zero; the FSM always reloads or leaves SHIFT there.
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StShift;
            end
            StShift: begin
                if (last_bit) begin
`ifdef SER_PARITY_EN
                    state_d = StPar;
`else
                    state_d = accept ? StShift : StIdle;
`endif
                end
            end
`ifdef SER_PARITY_EN
            StPar: begin
                state_d = accept ? StShift : StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output decode from state and registers only; ready is held low during reset.
    always_comb begin
        ready          = 1'b0;
        bus.sout       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.word_done  = 1'b0;
        bus.busy       = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
            end
            StShift: begin
                bus.sout       = shreg_q[WIDTH-1];
                bus.sout_valid = 1'b1;
                bus.busy       = 1'b1;
`ifndef SER_PARITY_EN
                bus.word_done  = last_bit;
                ready          = last_bit;
`endif
            end
`ifdef SER_PARITY_EN
            StPar: begin
                bus.sout       = par_q;
                bus.sout_valid = 1'b1;
                bus.busy       = 1'b1;
                bus.word_done  = 1'b1;
                ready          = 1'b1;
            end
`endif
            default: ;
        endcase
        if (rst) ready = 1'b0;
    end

    assign bus.din_ready = ready;
endmodule

// File: tb/tb_bit_serializer_tx.sv
// Scoreboard bench for bit_serializer_tx: the driver pushes every accepted
// word's expected serial bits (with the cycle each must appear in) into a queue;
// a monitor pops and compares whenever sout_valid is high.
module tb_bit_serializer_tx;
    localparam int unsigned WIDTH = 16;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic b;
        logic done;
        int   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    bit_serializer_tx_if #(.WIDTH(WIDTH)) bus ();

    bit_serializer_tx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected serial stream of one word accepted on the edge after the current negedge.
    task automatic push_word(input logic [WIDTH-1:0] w);
        int base;
        base = cyc + 1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            sb.push_back('{b: w[i], done: (i == 0) && !PAR, cyc: base + (WIDTH - 1 - i)});
        end
        if (PAR) sb.push_back('{b: ^w, done: 1'b1, cyc: base + WIDTH});
    endtask

    // Present w with valid high (called at a negedge) until accepted; returns at the
    // negedge after the accepting edge, din_valid still high.
    task automatic offer(input logic [WIDTH-1:0] w);
        bus.din       = w;
        bus.din_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (bus.din_ready === 1'b1) begin
                push_word(w);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bus.din_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.din = WIDTH'($urandom);
            @(negedge clk);
        end
    endtask

    // Monitor: one check per cycle, sampled at the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.sout_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_bit", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("bit_cycle", 32'(cyc), 32'(e.cyc));
                        chk("sout", 32'(bus.sout), 32'(e.b));
                        chk("word_done", 32'(bus.word_done), 32'(e.done));
                        // Ready only in the final cycle of a word.
                        chk("din_ready_busy", 32'(bus.din_ready), 32'(e.done));
                        chk("busy", 32'(bus.busy), 32'd1);
                    end
                end else begin
                    chk("idle_outputs", {29'd0, bus.sout, bus.word_done, bus.busy}, 32'd0);
                    chk("din_ready_idle", 32'(bus.din_ready), 32'd1);
                    if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                        chk("missing_bit", 32'(sb[0].cyc), 32'(cyc + 1));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus.din       = 16'hC3A5;
        bus.din_valid = 1'b1;
        // Reset with a valid word pending: nothing may be accepted or emitted.
        repeat (3) @(negedge clk);
        chk("rst_outputs", {27'd0, bus.sout, bus.sout_valid, bus.din_ready, bus.busy,
                            bus.word_done}, 32'd0);
        #1;
        rst           = 1'b0;
        bus.din_valid = 1'b0;
        @(negedge clk);

        // Directed words: single word, then a held-valid stream.
        offer(16'h5B56);
        idle(20);
        offer(16'hFFFF);
        offer(16'h0001);
        idle(20);
        offer(16'h0007);
        idle(20);

        // Reset during bit 7 of a word aborts it; next word starts cleanly.
        offer(16'hAAAA);
        bus.din_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("async_rst", {28'd0, bus.sout, bus.sout_valid, bus.din_ready, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        offer(16'h8001);
        idle(3);

        // Random words with random gaps (gap 0 streams back-to-back).
        for (int n = 0; n < 40; n++) begin
            offer(WIDTH'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
        end
        idle(1);

        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
